// File: rtl/layer_sequencer_pkg.sv
// Shared types for the layer sequencer: FSM state encoding and descriptor layout.
// Descriptor field widths come from the default engine/layer/address sizing here,
// so the top-level sizing parameters must agree with these values.
package layer_sequencer_pkg;

  localparam int NUM_ENGINES_DEF = 2;
  localparam int MAX_LAYERS_DEF  = 4;
  localparam int ADDR_WIDTH_DEF  = 8;
  localparam int ENG_ID_W        = (NUM_ENGINES_DEF > 1) ? $clog2(NUM_ENGINES_DEF) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ENG_RST,
    S_ENG_START,
    S_WAIT_DONE,
    S_NEXT,
    S_FINISH,
    S_ERROR
  } seq_state_t;

  typedef struct packed {
    logic [ENG_ID_W-1:0]       engine;
    logic [ADDR_WIDTH_DEF-1:0] in_addr;
    logic [ADDR_WIDTH_DEF-1:0] out_addr;
  } layer_desc_t;

endpackage

// File: rtl/layer_sequencer_if.sv
// Engine-side bundle of the layer sequencer: per-engine control, shared layer
// addresses, bus grant and the engines' memory requests.
// master = sequencer side, slave = engine side.
interface layer_sequencer_if #(
  parameter int NUM_ENGINES = 2,
  parameter int ADDR_WIDTH  = 8
);
  logic [NUM_ENGINES-1:0] eng_rst;
  logic [NUM_ENGINES-1:0] eng_start;
  logic [NUM_ENGINES-1:0] eng_done;
  logic [ADDR_WIDTH-1:0]  eng_in_addr;
  logic [ADDR_WIDTH-1:0]  eng_out_addr;
  logic [NUM_ENGINES-1:0] eng_mem_sel;
  logic [NUM_ENGINES-1:0] eng_mem_w;
  logic [NUM_ENGINES-1:0] bus_grant;

  modport master (
    output eng_rst, eng_start, eng_in_addr, eng_out_addr, bus_grant,
    input  eng_done, eng_mem_sel, eng_mem_w
  );

  modport slave (
    input  eng_rst, eng_start, eng_in_addr, eng_out_addr, bus_grant,
    output eng_done, eng_mem_sel, eng_mem_w
  );
endinterface

// File: rtl/layer_sequencer_desc_table.sv
// Layer descriptor register file: one synchronous write port, one async read port.
// Read data follows rd_idx combinationally; contents are not reset.
// Writes are gated by the caller (the sequencer only writes while idle).
module layer_sequencer_desc_table
  import layer_sequencer_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int IDX_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        we,
  input  logic [IDX_W-1:0] wr_idx,
  input  layer_desc_t wr_desc,
  input  logic [IDX_W-1:0] rd_idx,
  output layer_desc_t rd_desc
);

  layer_desc_t mem [DEPTH];

  // Descriptor write
  always_ff @(posedge clk) begin
    if (we) mem[wr_idx] <= wr_desc;
  end

  assign rd_desc = mem[rd_idx];

endmodule

// File: rtl/layer_sequencer.sv
// Runs a table of layer descriptors in order: reset engine, start it, grant it the bus until done.
// Latency per layer: ENG_RST + ENG_START + engine cycles + NEXT, plus one FINISH cycle per sequence.
// No backpressure: start/cfg_we are ignored while busy; abort cancels from any running state.
module layer_sequencer
  import layer_sequencer_pkg::*;
#(
  parameter int NUM_ENGINES = NUM_ENGINES_DEF,
  parameter int MAX_LAYERS  = MAX_LAYERS_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF,
  parameter int TIMEOUT     = 1024,
  parameter int IDX_W       = $clog2(MAX_LAYERS),
  parameter int EID_W       = (NUM_ENGINES > 1) ? $clog2(NUM_ENGINES) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we,
  input  logic [IDX_W-1:0]      cfg_idx,
  input  logic [EID_W-1:0]      cfg_engine,
  input  logic [ADDR_WIDTH-1:0] cfg_in_addr,
  input  logic [ADDR_WIDTH-1:0] cfg_out_addr,
  input  logic [IDX_W:0]        num_layers,
  input  logic                  start,
  input  logic                  abort,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic                  mem_sel,
  output logic                  mem_w,
  layer_sequencer_if.master     eng
);

  localparam int CNT_W  = IDX_W + 1;
  localparam int WDOG_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  seq_state_t             state, state_nxt;
  logic [IDX_W-1:0]       layer_idx;
  logic [CNT_W-1:0]       layer_cnt;
  logic [CNT_W-1:0]       nl_eff;
  logic [WDOG_W-1:0]      wdog;
  logic                   done_q, err_q;
  logic [NUM_ENGINES-1:0] abort_rst;
  logic [NUM_ENGINES-1:0] eng_sel;
  logic [NUM_ENGINES-1:0] rst_mask;
  logic [NUM_ENGINES-1:0] grant;
  logic                   eng_id_ok, start_ok, seq_abort, last_layer, wdog_hit, cur_done;
  layer_desc_t            cur, cfg_desc;

  assign cfg_desc = '{engine: cfg_engine, in_addr: cfg_in_addr, out_addr: cfg_out_addr};

  layer_sequencer_desc_table #(.DEPTH(MAX_LAYERS), .IDX_W(IDX_W)) u_table (
    .clk     (clk),
    .we      (cfg_we && (state == S_IDLE)),
    .wr_idx  (cfg_idx),
    .wr_desc (cfg_desc),
    .rd_idx  (layer_idx),
    .rd_desc (cur)
  );

  // Decode the active layer's engine id into a one-hot select
  always_comb begin
    eng_sel = '0;
    for (int i = 0; i < NUM_ENGINES; i++) begin
      if (int'(cur.engine) == i) eng_sel[i] = 1'b1;
    end
  end

  assign eng_id_ok  = int'(cur.engine) < NUM_ENGINES;
  // An invalid engine id resets every engine, since we cannot tell which one is at fault
  assign rst_mask   = eng_id_ok ? eng_sel : '1;
  // Simultaneous abort wins over start in IDLE
  assign start_ok   = start && !abort;
  assign seq_abort  = abort && (state != S_IDLE);
  // Layer counts above table depth would never match layer_idx, so clamp them
  assign nl_eff     = (int'(num_layers) > MAX_LAYERS) ? CNT_W'(MAX_LAYERS) : num_layers;
  assign last_layer = (CNT_W'(layer_idx) + CNT_W'(1)) == layer_cnt;
  assign wdog_hit   = (TIMEOUT > 0) && (int'(wdog) == TIMEOUT - 1);
  assign cur_done   = |(eng.eng_done & eng_sel);

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else      state <= state_nxt;
  end

  // Next-state logic; abort overrides every transition out of a running state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (start_ok && (num_layers != '0)) state_nxt = S_ENG_RST;
      S_ENG_RST:   state_nxt = eng_id_ok ? S_ENG_START : S_ERROR;
      S_ENG_START: state_nxt = S_WAIT_DONE;
      S_WAIT_DONE: begin
        if (cur_done)      state_nxt = S_NEXT;
        else if (wdog_hit) state_nxt = S_ERROR;
      end
      S_NEXT:      state_nxt = last_layer ? S_FINISH : S_ENG_RST;
      S_FINISH:    state_nxt = S_IDLE;
      S_ERROR:     state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
    if (seq_abort) state_nxt = S_IDLE;
  end

  // Sequence bookkeeping: layer index/count, watchdog, sticky done/err, abort reset pulse
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      layer_idx <= '0;
      layer_cnt <= '0;
      wdog      <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_rst <= '0;
    end else begin
      abort_rst <= '0;
      if ((state == S_IDLE) && start_ok) begin
        layer_idx <= '0;
        layer_cnt <= nl_eff;
        done_q    <= (num_layers == '0);
        err_q     <= 1'b0;
      end
      if (state == S_ENG_START)      wdog <= '0;
      else if (state == S_WAIT_DONE) wdog <= wdog + 1'b1;
      if (state == S_NEXT)           layer_idx <= layer_idx + 1'b1;
      if (state_nxt == S_FINISH)     done_q <= 1'b1;
      if (state_nxt == S_ERROR)      err_q <= 1'b1;
      if (seq_abort) begin
        done_q    <= 1'b0;
        err_q     <= 1'b0;
        abort_rst <= rst_mask;
      end
    end
  end

  // Engine-facing outputs decoded from state so async reset clears them at once
  always_comb begin
    eng.eng_rst      = abort_rst;
    eng.eng_start    = '0;
    eng.eng_in_addr  = '0;
    eng.eng_out_addr = '0;
    grant            = '0;
    case (state)
      S_ENG_RST: begin
        eng.eng_rst      = abort_rst | eng_sel;
        eng.eng_in_addr  = cur.in_addr;
        eng.eng_out_addr = cur.out_addr;
      end
      S_ENG_START: begin
        eng.eng_start    = eng_sel;
        grant            = eng_sel;
        eng.eng_in_addr  = cur.in_addr;
        eng.eng_out_addr = cur.out_addr;
      end
      S_WAIT_DONE: begin
        grant            = eng_sel;
        eng.eng_in_addr  = cur.in_addr;
        eng.eng_out_addr = cur.out_addr;
      end
      S_ERROR: eng.eng_rst = abort_rst | rst_mask;
      default: ;
    endcase
  end

  assign eng.bus_grant = grant;
  assign mem_sel       = |(grant & eng.eng_mem_sel);
  assign mem_w         = |(grant & eng.eng_mem_w);
  assign busy          = (state != S_IDLE) && (state != S_FINISH);
  assign done          = done_q;
  assign err           = err_q;

endmodule
